// File: rtl/mips_dbg_pkg.sv
// Shared debug-path definitions: dump FSM state encoding and default register-file geometry.
package mips_dbg_pkg;

    localparam int unsigned DBG_WIDTH  = 32;
    localparam int unsigned DBG_DEPTH  = 32;
    localparam int unsigned DBG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready word stream carrying one register-file entry and its index per transfer.
interface regfile_dump_reader_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks the register file through a spare async read port and streams every entry out,
// holding the core frozen so the snapshot stays coherent.
module regfile_dump_reader
    import mips_dbg_pkg::*;
#(
    parameter int unsigned WIDTH  = DBG_WIDTH,
    parameter int unsigned DEPTH  = DBG_DEPTH,
    parameter int unsigned ADDR_W = DBG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [WIDTH-1:0]      rd_data,
    output logic                  freeze,
    output logic                  busy,
    output logic                  done,
    regfile_dump_reader_if.master out_if
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_NXT = (DEPTH > 1) ? ADDR_W'(1) : '0;
    localparam logic              ONE_WORD  = 1'(DEPTH == 1);

    dump_state_e state;
    dump_state_e state_d;
    logic        freeze_d;
    logic        busy_d;
    logic        done_d;
    logic        hs_c;

    assign hs_c = out_if.out_valid && out_if.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state logic; abort outranks a same-cycle handshake
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (start) state_d = LOAD;
            LOAD: state_d = abort ? DONE : SEND;
            SEND: if (abort || (hs_c && out_if.out_last)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the upcoming state so they register in step with it
    always_comb begin
        freeze_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_d)
            IDLE: ;
            LOAD,
            SEND: begin
                freeze_d = 1'b1;
                busy_d   = 1'b1;
            end
            DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Read-address counter and output word register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr          <= '0;
            freeze           <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            out_if.out_valid <= 1'b0;
            out_if.out_data  <= '0;
            out_if.out_index <= '0;
            out_if.out_last  <= 1'b0;
        end else begin
            freeze <= freeze_d;
            busy   <= busy_d;
            done   <= done_d;
            unique case (state)
                IDLE: rd_addr <= '0;
                LOAD: begin
                    if (!abort) begin
                        out_if.out_data  <= rd_data;
                        out_if.out_index <= '0;
                        out_if.out_last  <= ONE_WORD;
                        out_if.out_valid <= 1'b1;
                        rd_addr          <= FIRST_NXT;
                    end
                end
                SEND: begin
                    if (abort) begin
                        out_if.out_valid <= 1'b0;
                    end else if (hs_c) begin
                        if (out_if.out_last) begin
                            out_if.out_valid <= 1'b0;
                        end else begin
                            out_if.out_data  <= rd_data;
                            out_if.out_index <= rd_addr;
                            out_if.out_last  <= (rd_addr == LAST_IDX);
                            // Final index is held rather than wrapped past the last register
                            if (rd_addr != LAST_IDX) rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                end
                DONE: rd_addr <= '0;
                default: rd_addr <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: a 32-entry instance plus a single-entry build.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst, start, abort, start1, abort1;
    logic [4:0]  rd_addr, rd_addr1;
    logic [31:0] rd_data, rd_data1;
    logic        freeze, busy, done, freeze1, busy1, done1;
    logic [31:0] regs [32];
    int          n_cmp = 0;
    int          n_fail = 0;

    regfile_dump_reader_if #(.WIDTH(32), .ADDR_W(5)) sif ();
    regfile_dump_reader_if #(.WIDTH(32), .ADDR_W(5)) sif1 ();

    regfile_dump_reader #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .rd_addr(rd_addr),
        .rd_data(rd_data), .freeze(freeze), .busy(busy), .done(done), .out_if(sif)
    );

    regfile_dump_reader #(.WIDTH(32), .DEPTH(1), .ADDR_W(5)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .freeze(freeze1), .busy(busy1), .done(done1), .out_if(sif1)
    );

    assign rd_data  = regs[rd_addr];
    assign rd_data1 = (rd_addr1 == 5'd0) ? 32'hC0DE_0000 : 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        sif.out_ready = 1'b0; sif1.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i);
        tick(); tick();
        n_cmp++; if ({freeze, busy, done, sif.out_valid, sif.out_last} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=00000", {freeze, busy, done, sif.out_valid, sif.out_last});
        end
        n_cmp++; if ({rd_addr, sif.out_index, sif.out_data} !== 42'd0) begin
            n_fail++; $display("FAIL reset_bus got addr=%0d idx=%0d data=%h exp=0", rd_addr, sif.out_index, sif.out_data);
        end
        n_cmp++; if ({freeze1, busy1, done1, sif1.out_valid, rd_addr1} !== 9'd0) begin
            n_fail++; $display("FAIL reset_d1 got=%b exp=0", {freeze1, busy1, done1, sif1.out_valid, rd_addr1});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_dump();
        int idx;
        sif.out_ready = 1'b1;
        start = 1'b1;
        for (int t = 1; t <= 37; t++) begin
            tick();
            start = 1'b0;
            idx = t - 2;
            n_cmp++; if (freeze !== (t >= 1 && t <= 33)) begin
                n_fail++; $display("FAIL full_freeze t=%0d got=%b exp=%b", t, freeze, (t >= 1 && t <= 33));
            end
            n_cmp++; if (busy !== (t >= 1 && t <= 34)) begin
                n_fail++; $display("FAIL full_busy t=%0d got=%b exp=%b", t, busy, (t >= 1 && t <= 34));
            end
            n_cmp++; if (done !== (t == 34)) begin
                n_fail++; $display("FAIL full_done t=%0d got=%b exp=%b", t, done, (t == 34));
            end
            n_cmp++; if (sif.out_valid !== (t >= 2 && t <= 33)) begin
                n_fail++; $display("FAIL full_valid t=%0d got=%b exp=%b", t, sif.out_valid, (t >= 2 && t <= 33));
            end
            if (t == 1) begin
                n_cmp++; if (rd_addr !== 5'd0) begin
                    n_fail++; $display("FAIL full_load_addr got=%0d exp=0", rd_addr);
                end
            end
            if (t >= 2 && t <= 33) begin
                n_cmp++; if (sif.out_index !== 5'(idx)) begin
                    n_fail++; $display("FAIL full_index t=%0d got=%0d exp=%0d", t, sif.out_index, idx);
                end
                n_cmp++; if (sif.out_data !== 32'hA000_0000 + 32'(idx)) begin
                    n_fail++; $display("FAIL full_data t=%0d got=%h exp=%h", t, sif.out_data, 32'hA000_0000 + 32'(idx));
                end
                n_cmp++; if (sif.out_last !== (idx == 31)) begin
                    n_fail++; $display("FAIL full_last t=%0d got=%b exp=%b", t, sif.out_last, (idx == 31));
                end
                n_cmp++; if (rd_addr !== 5'((idx < 31) ? idx + 1 : 31)) begin
                    n_fail++; $display("FAIL full_rd_addr t=%0d got=%0d exp=%0d", t, rd_addr, (idx < 31) ? idx + 1 : 31);
                end
            end
        end
    endtask

    // Full dump tracked by an expected-index counter; optional random stalls and stray starts
    task automatic stream_dump(input bit stall, input bit extra_starts, input string tag);
        int        exp_idx = 0;
        int        dones = 0;
        int        t = 0;
        bit        rdy;
        logic [7:0] lfsr = 8'hA5;
        sif.out_ready = 1'b1;
        start = 1'b1;
        while (t < 400) begin
            tick();
            t++;
            start = extra_starts && (t == 5 || t == 10);
            if (stall) begin
                lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                rdy = lfsr[0];
            end else begin
                rdy = 1'b1;
            end
            sif.out_ready = rdy;
            if (done) dones++;
            if (sif.out_valid) begin
                n_cmp++;
                if (exp_idx >= 32) begin
                    n_fail++; $display("FAIL %s extra_word t=%0d idx=%0d exp=none", tag, t, sif.out_index);
                end else if (sif.out_index !== 5'(exp_idx) || sif.out_data !== 32'hA000_0000 + 32'(exp_idx)
                             || sif.out_last !== (exp_idx == 31) || freeze !== 1'b1) begin
                    n_fail++; $display("FAIL %s word t=%0d got idx=%0d data=%h last=%b frz=%b exp idx=%0d", tag, t,
                                       sif.out_index, sif.out_data, sif.out_last, freeze, exp_idx);
                end
                if (rdy) exp_idx++;
            end
            if (dones > 0 && !busy) break;
        end
        start = 1'b0;
        n_cmp++; if (exp_idx != 32) begin
            n_fail++; $display("FAIL %s word_count got=%0d exp=32", tag, exp_idx);
        end
        n_cmp++; if (dones != 1) begin
            n_fail++; $display("FAIL %s done_count got=%0d exp=1", tag, dones);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if ({busy, sif.out_valid, done, rd_addr} !== 8'd0) begin
                n_fail++; $display("FAIL %s idle_after got busy=%b vld=%b done=%b addr=%0d exp=0", tag, busy,
                                   sif.out_valid, done, rd_addr);
            end
        end
    endtask

    task automatic test_stall();
        stream_dump(1'b1, 1'b0, "stall");
    endtask

    task automatic test_start_ignored();
        stream_dump(1'b0, 1'b1, "restart_ignored");
    endtask

    task automatic test_abort();
        sif.out_ready = 1'b1;
        start = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            start = 1'b0;
        end
        n_cmp++; if (sif.out_valid !== 1'b1 || sif.out_index !== 5'd7) begin
            n_fail++; $display("FAIL abort_pre got vld=%b idx=%0d exp vld=1 idx=7", sif.out_valid, sif.out_index);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++; if ({sif.out_valid, done, freeze, busy} !== 4'b0101) begin
            n_fail++; $display("FAIL abort_done got vld/done/frz/busy=%b exp=0101", {sif.out_valid, done, freeze, busy});
        end
        n_cmp++; if (sif.out_index !== 5'd7) begin
            n_fail++; $display("FAIL abort_index got=%0d exp=7", sif.out_index);
        end
        tick();
        n_cmp++; if ({done, busy, rd_addr} !== 7'd0) begin
            n_fail++; $display("FAIL abort_idle got done=%b busy=%b addr=%0d exp=0", done, busy, rd_addr);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (done !== 1'b0) begin
                n_fail++; $display("FAIL abort_single_done got=%b exp=0", done);
            end
        end
        stream_dump(1'b0, 1'b0, "abort_restart");
    endtask

    task automatic test_rst_mid();
        sif.out_ready = 1'b1;
        start = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            tick();
            start = 1'b0;
        end
        n_cmp++; if (sif.out_index !== 5'd12) begin
            n_fail++; $display("FAIL rst_pre_index got=%0d exp=12", sif.out_index);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({freeze, busy, done, sif.out_valid, sif.out_last} !== 5'b0) begin
            n_fail++; $display("FAIL rst_mid_flags got=%b exp=00000", {freeze, busy, done, sif.out_valid, sif.out_last});
        end
        n_cmp++; if ({rd_addr, sif.out_index, sif.out_data} !== 42'd0) begin
            n_fail++; $display("FAIL rst_mid_bus got addr=%0d idx=%0d data=%h exp=0", rd_addr, sif.out_index, sif.out_data);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if ({done, busy} !== 2'b00) begin
                n_fail++; $display("FAIL rst_mid_no_done got done=%b busy=%b exp=00", done, busy);
            end
        end
        stream_dump(1'b0, 1'b0, "rst_restart");
    endtask

    task automatic test_depth1();
        sif1.out_ready = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n_cmp++; if ({busy1, freeze1, sif1.out_valid, rd_addr1} !== 8'b110_00000) begin
            n_fail++; $display("FAIL d1_load got busy/frz/vld=%b addr=%0d exp=110 addr=0", {busy1, freeze1, sif1.out_valid}, rd_addr1);
        end
        for (int t = 2; t <= 3; t++) begin
            tick();
            n_cmp++; if (sif1.out_valid !== 1'b1 || sif1.out_index !== 5'd0 || sif1.out_last !== 1'b1
                         || sif1.out_data !== 32'hC0DE_0000 || rd_addr1 !== 5'd0 || done1 !== 1'b0) begin
                n_fail++; $display("FAIL d1_word t=%0d got vld=%b idx=%0d last=%b data=%h addr=%0d exp 1/0/1/c0de0000/0", t,
                                   sif1.out_valid, sif1.out_index, sif1.out_last, sif1.out_data, rd_addr1);
            end
        end
        sif1.out_ready = 1'b1;
        tick();
        sif1.out_ready = 1'b0;
        n_cmp++; if ({sif1.out_valid, done1, freeze1, busy1} !== 4'b0101) begin
            n_fail++; $display("FAIL d1_done got vld/done/frz/busy=%b exp=0101", {sif1.out_valid, done1, freeze1, busy1});
        end
        tick();
        n_cmp++; if ({done1, busy1, rd_addr1} !== 7'd0) begin
            n_fail++; $display("FAIL d1_idle got done=%b busy=%b addr=%0d exp=0", done1, busy1, rd_addr1);
        end
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_stall();
        test_start_ignored();
        test_abort();
        test_rst_mid();
        test_depth1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug/observation block that sequentially reads every architectural register out of the MIPS register file through one spare asynchronous read port.
- Streams the contents out over a valid/ready interface, one word per register, index 0 to DEPTH-1.
- Asserts a freeze request while a dump is in progress, so the core stalls and holds WE3 low and the snapshot stays coherent.
- Sits beside the register file; the debug/test harness is the consumer.

Parameters:
- WIDTH, 32, register data width.
- DEPTH, 32, number of registers dumped (indices 0..DEPTH-1).
- ADDR_W, 5, register index width; DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a dump; ignored unless idle.
- abort  in  1  terminate the dump in progress.
- rd_addr  out  ADDR_W  register index driven to the register file read port.
- rd_data  in  WIDTH  asynchronous read data returned for rd_addr in the same cycle.
- freeze  out  1  core stall request; high while a dump is active.
- out_valid  out  1  out_data/out_index hold a valid word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_data  out  WIDTH  register contents.
- out_index  out  ADDR_W  register index of out_data.
- out_last  out  1  current word is index DEPTH-1.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the last word is accepted or an abort completes.

Behaviour:
- Reset values: state=IDLE; rd_addr=0; out_valid=0; out_data=0; out_index=0; out_last=0; freeze=0; busy=0; done=0.
- States: IDLE, LOAD, SEND, DONE.
- IDLE:
  - rd_addr=0.
  - start=1 goes to LOAD next cycle; freeze and busy rise in that same next cycle.
- LOAD (exactly 1 cycle):
  - rd_addr=0.
  - At the clock edge: out_data<=rd_data, out_index<=0, out_last<=(DEPTH==1), rd_addr<=1, out_valid<=1; go to SEND.
  - First out_valid appears 2 cycles after start is sampled.
- SEND:
  - rd_addr always holds out_index+1, the next register, presented ahead of time.
  - out_valid stays high, and out_data/out_index/out_last stay stable, until a handshake occurs.
  - Handshake with out_last=0: out_data<=rd_data, out_index<=rd_addr, out_last<=(rd_addr==DEPTH-1), rd_addr<=rd_addr+1. Throughput is 1 word/cycle when out_ready is held high.
  - Handshake with out_last=1: out_valid<=0, go to DONE.
  - On the final word, rd_addr is not incremented past DEPTH-1; it is clamped and held.
- DONE (1 cycle): done=1, freeze=0, busy=1; go to IDLE with rd_addr<=0.
- abort:
  - In LOAD or SEND, abort has priority over any handshake in the same cycle: that word is not counted, out_valid<=0, go to DONE.
  - abort in IDLE or DONE has no effect.
- start while busy is ignored; no queuing.
- start and abort in the same IDLE cycle: start wins, because abort has no effect in IDLE.
- freeze is high in LOAD and SEND and low in IDLE and DONE. The block never writes the register file.
- rst asserted mid-dump: the next cycle shows reset values; no done pulse is produced.
- Full dump with out_ready tied high: start at cycle 0, words on cycles 2..DEPTH+1, done on cycle DEPTH+2.

Decomposition:
- Shared package mips_dbg_pkg holds:
  - the state encoding constants (IDLE=2'd0, LOAD=2'd1, SEND=2'd2, DONE=2'd3);
  - the default WIDTH/DEPTH/ADDR_W constants.
- No sub-module. State machine, index counter and output register live in one module.

Test Plan:
- Preload regs[i]=32'hA000_0000+i; out_ready=1; pulse start at cycle 0 -> 32 words on cycles 2..33 with out_index 0..31 and matching data, out_last only on index 31, done on cycle 34, freeze high on cycles 1..33.
- Same preload; out_ready toggles 1,0,0,1,... pseudo-randomly -> out_data/out_index held stable while stalled, no word dropped or duplicated, 32 words total.
- Start pulsed again at cycles 5 and 10 during a dump -> ignored; exactly one sequence of 32 words and a single done pulse.
- abort asserted at index 7 together with out_ready=1 -> word 7 not accepted, out_valid=0 next cycle, done pulses once, freeze low, next start restarts at index 0.
- rst asserted at index 12 -> next cycle all outputs at reset values, no done pulse; a subsequent start produces a full 0..31 dump.
- DEPTH=1 build; start -> single word with index 0 and out_last=1, done 1 cycle after its acceptance.
